dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port data memory (256 x 32-bit, synchronous write, asynchronous read, byte address divided by 4 internally). It shares that memory between the core load/store unit (port c) and the debug/DMA loader (port d). Requests are registered, issued to memory one at a time, and completed with a per-port response pulse. Arbitration is round-robin.

---
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port data memory between the core (c) and DMA (d) ports.
// Optional address/alignment checking is compiled in with DMEM_ARB_BOUNDS_EN.
module dmem_arbiter #(
    parameter int MEM_WORDS = 256,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [31:0]       c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_we,
    output logic [31:0]       mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t state, state_n;
    logic   last;        // 0 = c, 1 = d won the previous grant
    logic   cmd_port;
    logic   cmd_we;
    logic   rv_c, rv_d;
    logic   err_q;
    logic   acc_err;

`ifdef DMEM_ARB_BOUNDS_EN
    logic cmd_mis;
    assign acc_err = cmd_mis || (mem_a[31:2] >= 30'(MEM_WORDS));
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{c_addr[1:0], d_addr[1:0], err_q};
    assign acc_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            if (c_gnt || d_gnt)
                last <= d_gnt;
        end
    end

    always_comb begin
        state_n  = state;
        c_gnt    = 1'b0;
        d_gnt    = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        c_rvalid = 1'b0;
        d_rvalid = 1'b0;
        c_err    = 1'b0;
        d_err    = 1'b0;
        case (state)
            IDLE: if (c_req || d_req) state_n = ACC;
            ACC: begin
                state_n = RESP;
                busy    = 1'b1;
                mem_we  = cmd_we && !acc_err && !rst;
            end
            RESP: begin
                state_n  = (c_req || d_req) ? ACC : IDLE;
                c_rvalid = rv_c && !rst;
                d_rvalid = rv_d && !rst;
`ifdef DMEM_ARB_BOUNDS_EN
                c_err    = rv_c && err_q && !rst;
                d_err    = rv_d && err_q && !rst;
`endif
            end
            default: state_n = IDLE;
        endcase
        // On a tie, the port that did not win last time gets the grant.
        if ((state == IDLE || state == RESP) && !rst) begin
            c_gnt = c_req && (!d_req || last);
            d_gnt = d_req && (!c_req || !last);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_port <= 1'b0;
            cmd_we   <= 1'b0;
            mem_a    <= '0;
            mem_wd   <= '0;
            rv_c     <= 1'b0;
            rv_d     <= 1'b0;
            err_q    <= 1'b0;
            c_rdata  <= '0;
            d_rdata  <= '0;
`ifdef DMEM_ARB_BOUNDS_EN
            cmd_mis  <= 1'b0;
`endif
        end else begin
            // The command registers double as the memory address/data outputs, so they hold between accesses.
            if (c_gnt || d_gnt) begin
                cmd_port <= d_gnt;
                cmd_we   <= d_gnt ? d_we : c_we;
                mem_a    <= d_gnt ? {d_addr[31:2], 2'b00} : {c_addr[31:2], 2'b00};
                mem_wd   <= d_gnt ? d_wdata : c_wdata;
`ifdef DMEM_ARB_BOUNDS_EN
                cmd_mis  <= d_gnt ? (d_addr[1:0] != 2'b00) : (c_addr[1:0] != 2'b00);
`endif
            end
            rv_c  <= 1'b0;
            rv_d  <= 1'b0;
            err_q <= 1'b0;
            if (state == ACC) begin
                rv_c  <= !cmd_port;
                rv_d  <= cmd_port;
                err_q <= acc_err;
                if (acc_err) begin
                    if (cmd_port) d_rdata <= '0;
                    else          c_rdata <= '0;
                end else if (!cmd_we) begin
                    if (cmd_port) d_rdata <= mem_rd;
                    else          c_rdata <= mem_rd;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven cycle-by-cycle check of dmem_arbiter against hand-computed expectations, with a behavioural memory.
module tb_dmem_arbiter;
    localparam logic [7:0] F_CG = 8'h80, F_DG = 8'h40, F_CV = 8'h20, F_DV = 8'h10;
    localparam logic [7:0] F_CE = 8'h08, F_DE = 8'h04, F_WE = 8'h02, F_BZ = 8'h01;

    typedef struct {
        logic        rst;
        logic        c_req, c_we;
        logic [31:0] c_addr, c_wdata;
        logic        d_req, d_we;
        logic [31:0] d_addr, d_wdata;
        logic [7:0]  flags;
        logic [31:0] mem_a, mem_wd, c_rdata, d_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        busy;

    logic [31:0] mem [256];
    logic        mem_init;
    int          n_checks = 0;
    int          n_fail   = 0;
    vec_t        vq[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i * 6);
        end else if (mem_we) begin
            mem[mem_a[9:2]] <= mem_wd;
        end
    end
    assign mem_rd = mem[mem_a[9:2]];

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .busy(busy)
    );

    task automatic add(input logic r, input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dd, input logic [7:0] f, input logic [31:0] ma,
                       input logic [31:0] mw, input logic [31:0] crd, input logic [31:0] drd);
        vec_t v;
        v.rst = r; v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
        v.flags = f; v.mem_a = ma; v.mem_wd = mw; v.c_rdata = crd; v.d_rdata = drd;
        vq.push_back(v);
    endtask

    task automatic idle(input logic [7:0] f, input logic [31:0] ma, input logic [31:0] mw,
                        input logic [31:0] crd, input logic [31:0] drd);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, f, ma, mw, crd, drd);
    endtask

    task automatic check_mem(input string name, input int idx, input logic [31:0] exp);
        n_checks++;
        if (mem[idx] !== exp) begin
            n_fail++;
            $display("FAIL %s: mem[%0d] got %h expected %h", name, idx, mem[idx], exp);
        end
    endtask

    initial begin
        logic [7:0]  f;
        logic [31:0] got_flags;
        // reset state, then single core read of word 1
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 32'h4, 0, 0, 0, 0, 0, F_CG, 0, 0, 0, 0);
        idle(F_BZ, 32'h4, 0, 0, 0);
        idle(F_CV, 32'h4, 0, 32'h6, 0);
        // DMA write then core read of the same word; core request arrives during ACC
        add(0, 0, 0, 0, 0, 1, 1, 32'h8, 32'hDEADBEEF, F_DG, 32'h4, 0, 32'h6, 0);
        add(0, 1, 0, 32'h8, 0, 0, 0, 0, 0, F_BZ | F_WE, 32'h8, 32'hDEADBEEF, 32'h6, 0);
        add(0, 1, 0, 32'h8, 0, 0, 0, 0, 0, F_CG | F_DV, 32'h8, 32'hDEADBEEF, 32'h6, 0);
        idle(F_BZ, 32'h8, 0, 32'h6, 0);
        idle(F_CV, 32'h8, 0, 32'hDEADBEEF, 0);
        // requests held across reset, then 8 grants with both ports requesting
        add(1, 1, 0, 32'h4, 0, 1, 0, 32'hC, 0, 8'h00, 32'h8, 0, 32'hDEADBEEF, 0);
        for (int g = 0; g < 8; g++) begin
            f = (g % 2 == 0) ? F_CG : F_DG;
            if (g > 0) f |= (g % 2 == 1) ? F_CV : F_DV;
            add(0, 1, 0, 32'h4, 0, 1, 0, 32'hC, 0, f,
                (g == 0) ? 32'h0 : ((g % 2 == 1) ? 32'h4 : 32'hC), 0,
                (g >= 1) ? 32'h6 : 32'h0, (g >= 2) ? 32'h12 : 32'h0);
            add(0, 1, 0, 32'h4, 0, 1, 0, 32'hC, 0, F_BZ,
                (g % 2 == 0) ? 32'h4 : 32'hC, 0,
                (g >= 1) ? 32'h6 : 32'h0, (g >= 2) ? 32'h12 : 32'h0);
        end
        idle(F_DV, 32'hC, 0, 32'h6, 32'h12);
        // reset during the ACC cycle of a write
        add(0, 1, 1, 32'h10, 32'h55, 0, 0, 0, 0, F_CG, 32'hC, 0, 32'h6, 32'h12);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, F_BZ, 32'h10, 32'h55, 32'h6, 32'h12);
        idle(8'h00, 0, 0, 0, 0);
        // core request dropped while DMA access is in ACC
        add(0, 0, 0, 0, 0, 1, 0, 32'h4, 0, F_DG, 0, 0, 0, 0);
        add(0, 1, 1, 32'h14, 32'h77, 0, 0, 0, 0, F_BZ, 32'h4, 0, 0, 0);
        idle(F_DV, 32'h4, 0, 0, 32'h6);
        idle(8'h00, 32'h4, 0, 0, 32'h6);
        idle(8'h00, 32'h4, 0, 0, 32'h6);
        // misaligned core write
        add(0, 1, 1, 32'h6, 32'hA5, 0, 0, 0, 0, F_CG, 32'h4, 0, 0, 32'h6);
`ifdef DMEM_ARB_BOUNDS_EN
        idle(F_BZ, 32'h4, 32'hA5, 0, 32'h6);
        idle(F_CV | F_CE, 32'h4, 32'hA5, 0, 32'h6);
        idle(8'h00, 32'h4, 32'hA5, 0, 32'h6);
        // out-of-range core write
        add(0, 1, 1, 32'h400, 32'h1, 0, 0, 0, 0, F_CG, 32'h4, 32'hA5, 0, 32'h6);
        idle(F_BZ, 32'h400, 32'h1, 0, 32'h6);
        idle(F_CV | F_CE, 32'h400, 32'h1, 0, 32'h6);
        idle(8'h00, 32'h400, 32'h1, 0, 32'h6);
`else
        idle(F_BZ | F_WE, 32'h4, 32'hA5, 0, 32'h6);
        idle(F_CV, 32'h4, 32'hA5, 0, 32'h6);
        idle(8'h00, 32'h4, 32'hA5, 0, 32'h6);
`endif

        rst = 1'b1; mem_init = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        @(posedge clk);
        @(posedge clk);
        #1 mem_init = 1'b0;

        foreach (vq[i]) begin
            if (i > 0) @(posedge clk);
            #1;
            rst = vq[i].rst;
            c_req = vq[i].c_req; c_we = vq[i].c_we; c_addr = vq[i].c_addr; c_wdata = vq[i].c_wdata;
            d_req = vq[i].d_req; d_we = vq[i].d_we; d_addr = vq[i].d_addr; d_wdata = vq[i].d_wdata;
            #2;
            got_flags = {24'h0, c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, mem_we, busy};
            n_checks++;
            if (got_flags[7:0] !== vq[i].flags || mem_a !== vq[i].mem_a || mem_wd !== vq[i].mem_wd ||
                c_rdata !== vq[i].c_rdata || d_rdata !== vq[i].d_rdata) begin
                n_fail++;
                $display("FAIL vec%0d: got flags=%b mem_a=%h mem_wd=%h c_rdata=%h d_rdata=%h; expected flags=%b mem_a=%h mem_wd=%h c_rdata=%h d_rdata=%h",
                         i, got_flags[7:0], mem_a, mem_wd, c_rdata, d_rdata,
                         vq[i].flags, vq[i].mem_a, vq[i].mem_wd, vq[i].c_rdata, vq[i].d_rdata);
            end
        end
        @(posedge clk);
        #1;

        check_mem("dma_write", 2, 32'hDEADBEEF);
        check_mem("reset_in_acc", 4, 32'd24);
        check_mem("dropped_req", 5, 32'd30);
`ifdef DMEM_ARB_BOUNDS_EN
        check_mem("misaligned_write", 1, 32'd6);
        check_mem("oob_write", 0, 32'd0);
`else
        check_mem("misaligned_write", 1, 32'hA5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
